// File: rtl/vector_pool_mc_if.sv
// Bus bundle for the multi-channel pooling reducer: input beat stream
// and the registered pooled-result side.
interface vector_pool_mc_if #(
  parameter int CH    = 4,
  parameter int DIN_W = 16,
  parameter int CNT_W = 8
);
  logic                  op_din_en;
  logic                  op_din_eop;
  logic [CH*DIN_W-1:0]   op_din;
  logic                  op_dout_en;
  logic [CH*DIN_W-1:0]   op_dout;
  logic [CNT_W-1:0]      op_dout_cnt;
  logic                  op_dout_ovf;

  // Producer of beats / consumer of results
  modport master (
    output op_din_en, op_din_eop, op_din,
    input  op_dout_en, op_dout, op_dout_cnt, op_dout_ovf
  );

  // The reducer itself
  modport slave (
    input  op_din_en, op_din_eop, op_din,
    output op_dout_en, op_dout, op_dout_cnt, op_dout_ovf
  );
endinterface

// File: rtl/vector_pool_mc.sv
// Multi-channel pooling reducer: per-lane max or rounded average over a
// window of beats terminated by eop, optional ReLU, beat count and
// sticky overflow. Result is registered one cycle after the eop beat.
module vector_pool_mc #(
  parameter int CH        = 4,
  parameter int DIN_W     = 16,
  parameter int MODE      = 0,
  parameter int AVG_SHIFT = 2,
  parameter int CNT_W     = 8,
  parameter int RELU      = 0
) (
  input logic              clk,
  input logic              rst,
  vector_pool_mc_if.slave  bus
);

  // One accumulator width for both modes; in max mode the extra bits are
  // just sign extension, which keeps the compare and the sum uniform.
  localparam int ACC_W = DIN_W + CNT_W;

  localparam logic signed [ACC_W-1:0] ACC_INIT = (MODE == 0) ?
    {{(CNT_W+1){1'b1}}, {(DIN_W-1){1'b0}}} : {ACC_W{1'b0}};

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  // Rounding constant 2^(AVG_SHIFT-1), zero when no division is applied.
  localparam int RND_SH = (AVG_SHIFT > 0) ? AVG_SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND_S = (AVG_SHIFT > 0) ?
    ({{ACC_W{1'b0}}, 1'b1} << RND_SH) : {(ACC_W+1){1'b0}};

  localparam logic signed [ACC_W:0] SAT_HI =
    {{(ACC_W-DIN_W+2){1'b0}}, {(DIN_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_LO =
    {{(ACC_W-DIN_W+2){1'b1}}, {(DIN_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_q   [CH];
  logic signed [ACC_W-1:0] acc_d   [CH];
  logic signed [ACC_W-1:0] acc_nxt [CH];
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_nxt;
  logic                    ovf_q, ovf_d, ovf_nxt;
  logic                    dout_en_q, dout_en_d;
  logic [CH*DIN_W-1:0]     dout_q, dout_d;
  logic [CNT_W-1:0]        dout_cnt_q, dout_cnt_d;
  logic                    dout_ovf_q, dout_ovf_d;

  // Sign-extend one input lane to accumulator width.
  function automatic logic signed [ACC_W-1:0] ext_lane(input logic [DIN_W-1:0] x);
    return {{CNT_W{x[DIN_W-1]}}, x};
  endfunction

  // Turn a lane accumulator into the output lane: round/shift/saturate in
  // average mode, pass through in max mode, then optional ReLU.
  function automatic logic [DIN_W-1:0] finish_lane(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] wide_s;
    logic signed [ACC_W:0] shr_s;
    logic [DIN_W-1:0]      r;
    wide_s = {a[ACC_W-1], a};
    shr_s  = wide_s;
    if (MODE == 1) begin
      wide_s = wide_s + RND_S;
      shr_s  = wide_s >>> AVG_SHIFT;
      if (shr_s > SAT_HI) begin
        r = SAT_HI[DIN_W-1:0];
      end else if (shr_s < SAT_LO) begin
        r = SAT_LO[DIN_W-1:0];
      end else begin
        r = shr_s[DIN_W-1:0];
      end
    end else begin
      r = a[DIN_W-1:0];
    end
    if ((RELU == 1) && r[DIN_W-1]) begin
      r = {DIN_W{1'b0}};
    end else begin
      r = r;
    end
    return r;
  endfunction

  // Fold the current beat into the window state and, on eop, form the
  // result and reinitialise so the next cycle can start a new window.
  always_comb begin
    acc_nxt    = acc_q;
    acc_d      = acc_q;
    cnt_nxt    = cnt_q;
    ovf_nxt    = ovf_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    dout_en_d  = 1'b0;
    dout_d     = dout_q;
    dout_cnt_d = dout_cnt_q;
    dout_ovf_d = dout_ovf_q;

    for (int k = 0; k < CH; k++) begin
      if (bus.op_din_en) begin
        if (MODE == 0) begin
          if (ext_lane(bus.op_din[k*DIN_W +: DIN_W]) > acc_q[k]) begin
            acc_nxt[k] = ext_lane(bus.op_din[k*DIN_W +: DIN_W]);
          end else begin
            acc_nxt[k] = acc_q[k];
          end
        end else begin
          acc_nxt[k] = acc_q[k] + ext_lane(bus.op_din[k*DIN_W +: DIN_W]);
        end
      end else begin
        acc_nxt[k] = acc_q[k];
      end
    end

    if (bus.op_din_en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_nxt = cnt_q;
        ovf_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_q + CNT_ONE;
        ovf_nxt = ovf_q;
      end
    end else begin
      cnt_nxt = cnt_q;
      ovf_nxt = ovf_q;
    end

    if (bus.op_din_en && bus.op_din_eop) begin
      dout_en_d  = 1'b1;
      dout_cnt_d = cnt_nxt;
      dout_ovf_d = ovf_nxt;
      for (int k = 0; k < CH; k++) begin
        dout_d[k*DIN_W +: DIN_W] = finish_lane(acc_nxt[k]);
        acc_d[k] = ACC_INIT;
      end
      cnt_d = {CNT_W{1'b0}};
      ovf_d = 1'b0;
    end else begin
      acc_d = acc_nxt;
      cnt_d = cnt_nxt;
      ovf_d = ovf_nxt;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CH; k++) begin
        acc_q[k] <= ACC_INIT;
      end
      cnt_q      <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
      dout_en_q  <= 1'b0;
      dout_q     <= {(CH*DIN_W){1'b0}};
      dout_cnt_q <= {CNT_W{1'b0}};
      dout_ovf_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      dout_en_q  <= dout_en_d;
      dout_q     <= dout_d;
      dout_cnt_q <= dout_cnt_d;
      dout_ovf_q <= dout_ovf_d;
    end
  end

  assign bus.op_dout_en  = dout_en_q;
  assign bus.op_dout     = dout_q;
  assign bus.op_dout_cnt = dout_cnt_q;
  assign bus.op_dout_ovf = dout_ovf_q;

endmodule

// File: tb/tb_vector_pool_mc.sv
// Directed bench: five reducer configurations share one beat stream.
// Lanes 0,2,3 carry v and lane 1 carries -v on every beat.
module tb_vector_pool_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_en = 1'b0;
  logic        din_eop = 1'b0;
  logic [63:0] din = 64'd0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          strobes_a = 0;

  always #5 clk = ~clk;

  // a: max, b: max+relu, c: avg shift 2, d: avg shift 0, e: max with 4-bit counter
  vector_pool_mc_if #(.CH(4), .DIN_W(16), .CNT_W(8)) if_a ();
  vector_pool_mc_if #(.CH(4), .DIN_W(16), .CNT_W(8)) if_b ();
  vector_pool_mc_if #(.CH(4), .DIN_W(16), .CNT_W(8)) if_c ();
  vector_pool_mc_if #(.CH(4), .DIN_W(16), .CNT_W(8)) if_d ();
  vector_pool_mc_if #(.CH(4), .DIN_W(16), .CNT_W(4)) if_e ();

  vector_pool_mc #(.CH(4), .DIN_W(16), .MODE(0), .AVG_SHIFT(2), .CNT_W(8), .RELU(0))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  vector_pool_mc #(.CH(4), .DIN_W(16), .MODE(0), .AVG_SHIFT(2), .CNT_W(8), .RELU(1))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  vector_pool_mc #(.CH(4), .DIN_W(16), .MODE(1), .AVG_SHIFT(2), .CNT_W(8), .RELU(0))
    u_c (.clk(clk), .rst(rst), .bus(if_c));
  vector_pool_mc #(.CH(4), .DIN_W(16), .MODE(1), .AVG_SHIFT(0), .CNT_W(8), .RELU(0))
    u_d (.clk(clk), .rst(rst), .bus(if_d));
  vector_pool_mc #(.CH(4), .DIN_W(16), .MODE(0), .AVG_SHIFT(2), .CNT_W(4), .RELU(0))
    u_e (.clk(clk), .rst(rst), .bus(if_e));

  assign if_a.op_din_en = din_en;  assign if_a.op_din_eop = din_eop;  assign if_a.op_din = din;
  assign if_b.op_din_en = din_en;  assign if_b.op_din_eop = din_eop;  assign if_b.op_din = din;
  assign if_c.op_din_en = din_en;  assign if_c.op_din_eop = din_eop;  assign if_c.op_din = din;
  assign if_d.op_din_en = din_en;  assign if_d.op_din_eop = din_eop;  assign if_d.op_din = din;
  assign if_e.op_din_en = din_en;  assign if_e.op_din_eop = din_eop;  assign if_e.op_din = din;

  // Count result strobes of the reference max instance
  always @(posedge clk) begin
    if (if_a.op_dout_en) strobes_a <= strobes_a + 1;
  end

  typedef struct {
    int nb;
    int v[4];
    bit gap;
    int a0, a1, b0, b1, c0, c1, d0, d1;
    int cnt;
  } win_t;

  win_t tbl[6];

  function automatic win_t mk(int nb, int v0, int v1, int v2, int v3, bit gap,
                              int a0, int a1, int b0, int b1,
                              int c0, int c1, int d0, int d1, int cnt);
    win_t w;
    w.nb = nb; w.v[0] = v0; w.v[1] = v1; w.v[2] = v2; w.v[3] = v3; w.gap = gap;
    w.a0 = a0; w.a1 = a1; w.b0 = b0; w.b1 = b1;
    w.c0 = c0; w.c1 = c1; w.d0 = d0; w.d1 = d1; w.cnt = cnt;
    return w;
  endfunction

  // Lane0/2/3 = e0, lane1 = e1
  function automatic logic [63:0] pk2(int e0, int e1);
    logic [15:0] a;
    logic [15:0] b;
    a = e0[15:0];
    b = e1[15:0];
    return {a, a, b, a};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic beat(int v, bit eop);
    @(negedge clk);
    din_en  = 1'b1;
    din_eop = eop;
    din     = pk2(v, -v);
  endtask

  // Idle cycle; eop may be high to show it is ignored without en
  task automatic idle(bit eop);
    @(negedge clk);
    din_en  = 1'b0;
    din_eop = eop;
  endtask

  task automatic check_win(int i, win_t w);
    chk($sformatf("w%0d_a_en", i),   64'(if_a.op_dout_en), 64'd1);
    chk($sformatf("w%0d_a_dout", i), if_a.op_dout, pk2(w.a0, w.a1));
    chk($sformatf("w%0d_a_cnt", i),  64'(if_a.op_dout_cnt), 64'(w.cnt));
    chk($sformatf("w%0d_a_ovf", i),  64'(if_a.op_dout_ovf), 64'd0);
    chk($sformatf("w%0d_b_en", i),   64'(if_b.op_dout_en), 64'd1);
    chk($sformatf("w%0d_b_dout", i), if_b.op_dout, pk2(w.b0, w.b1));
    chk($sformatf("w%0d_c_en", i),   64'(if_c.op_dout_en), 64'd1);
    chk($sformatf("w%0d_c_dout", i), if_c.op_dout, pk2(w.c0, w.c1));
    chk($sformatf("w%0d_c_cnt", i),  64'(if_c.op_dout_cnt), 64'(w.cnt));
    chk($sformatf("w%0d_d_dout", i), if_d.op_dout, pk2(w.d0, w.d1));
    chk($sformatf("w%0d_e_dout", i), if_e.op_dout, pk2(w.a0, w.a1));
    chk($sformatf("w%0d_e_cnt", i),  64'(if_e.op_dout_cnt), 64'(w.cnt));
  endtask

  initial begin
    //            nb  beats                     gap  a0     a1      b0     b1  c0     c1      d0      d1     cnt
    tbl[0] = mk(4,  3,     -7,    12,    5,     1'b1, 12,    7,      12,    7,  3,     -3,     13,     -13,    4);
    tbl[1] = mk(3, -5,     -2,    -9,    0,     1'b0, -2,    9,      0,     9,  -4,    4,      -16,    16,     3);
    tbl[2] = mk(4,  1,      2,     3,    4,     1'b0, 4,     -1,     4,     0,  3,     -2,     10,     -10,    4);
    tbl[3] = mk(4, -1,     -1,    -1,   -2,     1'b0, -1,    2,      0,     2,  -1,    1,      -5,     5,      4);
    tbl[4] = mk(4, 32767, 32767, 32767, 32767,  1'b0, 32767, -32767, 32767, 0,  32767, -32767, 32767,  -32768, 4);
    tbl[5] = mk(2, 30000, 30000, 0,     0,      1'b0, 30000, -30000, 30000, 0,  15000, -15000, 32767,  -32768, 2);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_en",   64'(if_a.op_dout_en), 64'd0);
    chk("rst_a_dout", if_a.op_dout, 64'd0);
    chk("rst_a_cnt",  64'(if_a.op_dout_cnt), 64'd0);
    chk("rst_a_ovf",  64'(if_a.op_dout_ovf), 64'd0);
    chk("rst_c_dout", if_c.op_dout, 64'd0);
    chk("rst_e_cnt",  64'(if_e.op_dout_cnt), 64'd0);
    rst = 1'b0;
    idle(1'b0);

    // Table-driven windows
    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < tbl[i].nb; b++) begin
        beat(tbl[i].v[b], b == tbl[i].nb - 1);
        if (tbl[i].gap && (b < tbl[i].nb - 1)) idle(1'b1);
      end
      idle(1'b0);
      check_win(i, tbl[i]);
      idle(1'b0);
      chk($sformatf("w%0d_a_en_drop", i), 64'(if_a.op_dout_en), 64'd0);
      chk($sformatf("w%0d_a_hold", i),    if_a.op_dout, pk2(tbl[i].a0, tbl[i].a1));
    end

    // Back-to-back single-beat windows
    beat(10, 1'b1);
    beat(20, 1'b1);
    chk("b2b0_a_en",   64'(if_a.op_dout_en), 64'd1);
    chk("b2b0_a_dout", if_a.op_dout, pk2(10, -10));
    chk("b2b0_a_cnt",  64'(if_a.op_dout_cnt), 64'd1);
    chk("b2b0_c_dout", if_c.op_dout, pk2(3, -2));
    beat(30, 1'b1);
    chk("b2b1_a_en",   64'(if_a.op_dout_en), 64'd1);
    chk("b2b1_a_dout", if_a.op_dout, pk2(20, -20));
    chk("b2b1_a_cnt",  64'(if_a.op_dout_cnt), 64'd1);
    chk("b2b1_c_dout", if_c.op_dout, pk2(5, -5));
    idle(1'b0);
    chk("b2b2_a_en",   64'(if_a.op_dout_en), 64'd1);
    chk("b2b2_a_dout", if_a.op_dout, pk2(30, -30));
    chk("b2b2_a_cnt",  64'(if_a.op_dout_cnt), 64'd1);
    chk("b2b2_c_dout", if_c.op_dout, pk2(8, -7));
    chk("b2b2_b_dout", if_b.op_dout, pk2(30, 0));
    idle(1'b0);
    chk("b2b_a_en_drop", 64'(if_a.op_dout_en), 64'd0);

    // Counter saturation: 17 beats plus eop beat (18 total)
    for (int i = 0; i < 17; i++) beat(i, 1'b0);
    beat(17, 1'b1);
    idle(1'b0);
    chk("ovf_e_en",   64'(if_e.op_dout_en), 64'd1);
    chk("ovf_e_cnt",  64'(if_e.op_dout_cnt), 64'd15);
    chk("ovf_e_ovf",  64'(if_e.op_dout_ovf), 64'd1);
    chk("ovf_e_dout", if_e.op_dout, pk2(17, 0));
    chk("ovf_a_cnt",  64'(if_a.op_dout_cnt), 64'd18);
    chk("ovf_a_ovf",  64'(if_a.op_dout_ovf), 64'd0);
    beat(1, 1'b0);
    beat(2, 1'b1);
    idle(1'b0);
    chk("ovf2_e_cnt",  64'(if_e.op_dout_cnt), 64'd2);
    chk("ovf2_e_ovf",  64'(if_e.op_dout_ovf), 64'd0);
    chk("ovf2_e_dout", if_e.op_dout, pk2(2, -1));

    // Reset mid-window discards the partial window
    beat(100, 1'b0);
    beat(100, 1'b0);
    @(negedge clk);
    din_en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_a_en",   64'(if_a.op_dout_en), 64'd0);
    chk("mrst_a_dout", if_a.op_dout, 64'd0);
    chk("mrst_a_cnt",  64'(if_a.op_dout_cnt), 64'd0);
    idle(1'b0);
    chk("mrst_a_en2",  64'(if_a.op_dout_en), 64'd0);
    beat(7, 1'b0);
    beat(8, 1'b1);
    chk("mrst_a_pre",  if_a.op_dout, 64'd0);
    idle(1'b0);
    chk("mrst_a_en3",  64'(if_a.op_dout_en), 64'd1);
    chk("mrst_a_dout2", if_a.op_dout, pk2(8, -7));
    chk("mrst_a_cnt2", 64'(if_a.op_dout_cnt), 64'd2);
    chk("mrst_c_dout", if_c.op_dout, pk2(4, -4));
    idle(1'b0);
    idle(1'b0);

    // 6 table windows + 3 back-to-back + 2 overflow + 1 after reset
    chk("a_strobes", 64'(strobes_a), 64'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
